// File: rtl/busca_instrucao.sv
// busca_instrucao: instruction-fetch stage feeding the control unit.
// Holds the PC, fetches one instruction at a time from a variable-latency
// imem over a req/ready handshake, latches it, and commits the next PC
// (sequential, beq or j) when the datapath signals exec_done.
//
// Optional build macro: FETCH_TIMEOUT_EN
//   Adds an 8-bit wait counter and a terminal S_ERROR state. The fetch
//   aborts with a sticky fetch_error after TIMEOUT_CYCLES wait cycles.
//   When the macro is undefined, fetch_error is constant 0.
//
// Ports:
//   clock, reset_n        rising-edge clock, async active-low reset
//   imem_req/addr         fetch request and address (address == pc)
//   imem_ready/rdata      imem data-valid strobe and instruction word
//   instr, opcode         latched instruction and its [31:26] field
//   instr_valid           high while the latched instruction executes
//   pc, pc_plus4          current PC and pc + 4 (combinational)
//   branch, zero, jump    next-PC controls, sampled with exec_done
//   exec_done             commit the next PC and return to fetch
//   instr_count           committed instruction counter (wraps)
//   fetch_error           sticky imem timeout flag
module busca_instrucao #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        exec_done,
    output logic [31:0] instr_count,
    output logic        fetch_error
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
`ifdef FETCH_TIMEOUT_EN
    localparam logic [1:0] S_ERROR = 2'd2;
    localparam int unsigned CNT_W  = 8;
`endif

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_req;
    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_count;

    logic        w_req_nxt;
    logic        w_valid_nxt;
    logic        w_capture;
    logic        w_commit;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_next_pc;

`ifdef FETCH_TIMEOUT_EN
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic             r_fetch_error;
    logic             w_err_set;
`else
    logic             w_unused_cfg;
    assign w_unused_cfg = ^32'(TIMEOUT_CYCLES);
`endif

    // PC arithmetic; all sums wrap modulo 2^32
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    // Next-PC select; jump takes priority over a taken branch
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jump) begin
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (branch && zero) begin
            w_next_pc = w_pc_plus4 + w_br_off;
        end
    end

    // Next-state logic. A fetch is only accepted while the request is
    // actually on the bus, so the reset-release cycle (req still 0) waits.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_commit    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        w_wait_cnt_nxt = r_wait_cnt;
        w_err_set      = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                if (r_req) begin
                    if (imem_ready) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_EXEC;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                    end
`endif
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
                    w_wait_cnt_nxt = '0;
`endif
                end
            end
`ifdef FETCH_TIMEOUT_EN
            S_ERROR: begin
                w_state_nxt = S_ERROR;
            end
`endif
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
        w_req_nxt   = (w_state_nxt == S_FETCH);
        w_valid_nxt = (w_state_nxt == S_EXEC);
    end

    // State, handshake outputs, PC, instruction and commit counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_valid <= w_valid_nxt;
            if (w_capture) begin
                r_instr <= imem_rdata;
            end
            if (w_commit) begin
                r_pc    <= w_next_pc;
                r_count <= r_count + 32'd1;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Wait counter and sticky timeout flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt    <= '0;
            r_fetch_error <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_err_set) begin
                r_fetch_error <= 1'b1;
            end
        end
    end

    assign fetch_error = r_fetch_error;
`else
    assign fetch_error = 1'b0;
`endif

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign instr_valid = r_valid;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign instr_count = r_count;

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: a table of instructions executed back
// to back with hand-computed opcodes and next PCs, plus sequences for
// delayed ready, async reset mid-execute, and the fetch-timeout option.
// A second instance with RESET_PC=32'hFFFF_FFFC shares all inputs to cover
// the pc + 4 wrap.
module tb_busca_instrucao;

    logic        clock;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch;
    logic        zero;
    logic        jump;
    logic        exec_done;
    logic [31:0] instr_count;
    logic        fetch_error;

    logic        w_req2;
    logic [31:0] w_addr2;
    logic [31:0] w_instr2;
    logic [5:0]  w_op2;
    logic        w_valid2;
    logic [31:0] w_pc2;
    logic [31:0] w_pcp4_2;
    logic [31:0] w_cnt2;
    logic        w_err2;

    int n_vec;
    int n_err;

    busca_instrucao #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4),
        .branch(branch), .zero(zero), .jump(jump), .exec_done(exec_done),
        .instr_count(instr_count), .fetch_error(fetch_error)
    );

    busca_instrucao #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(16)) u_wrap (
        .clock(clock), .reset_n(reset_n),
        .imem_req(w_req2), .imem_addr(w_addr2),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(w_instr2), .opcode(w_op2), .instr_valid(w_valid2),
        .pc(w_pc2), .pc_plus4(w_pcp4_2),
        .branch(branch), .zero(zero), .jump(jump), .exec_done(exec_done),
        .instr_count(w_cnt2), .fetch_error(w_err2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rdata;
        logic        br;
        logic        zr;
        logic        jp;
        logic [5:0]  op;
        logic [31:0] pc_after;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc;
        n_vec = 0;
        n_err = 0;

        // Each row starts from the PC left by the previous one (reset PC 0)
        vecs[0] = '{32'h8C01_0004, 1'b0, 1'b0, 1'b0, 6'h23, 32'h0000_0004};
        vecs[1] = '{32'h0800_0040, 1'b0, 1'b0, 1'b1, 6'h02, 32'h0000_0100};
        vecs[2] = '{32'h1000_0003, 1'b1, 1'b1, 1'b0, 6'h04, 32'h0000_0110};
        vecs[3] = '{32'h1000_0003, 1'b1, 1'b0, 1'b0, 6'h04, 32'h0000_0114};
        vecs[4] = '{32'h0810_0000, 1'b0, 1'b0, 1'b1, 6'h02, 32'h0040_0000};
        vecs[5] = '{32'h0810_0010, 1'b1, 1'b1, 1'b1, 6'h02, 32'h0040_0040};
        vecs[6] = '{32'h1000_FFFE, 1'b1, 1'b1, 1'b0, 6'h04, 32'h0040_003C};
        vecs[7] = '{32'h2001_0005, 1'b0, 1'b1, 1'b0, 6'h08, 32'h0040_0040};

        reset_n    = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        branch     = 1'b0;
        zero       = 1'b0;
        jump       = 1'b0;
        exec_done  = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst pc", pc, 32'h0);
        chk("rst instr", instr, 32'h0);
        chk("rst count", instr_count, 32'h0);
        chk("rst pc_plus4", pc_plus4, 32'h4);
        chk("rst wrap pc", w_pc2, 32'hFFFF_FFFC);
        chk("rst wrap pc_plus4", w_pcp4_2, 32'h0);
        repeat (2) step();
        chk("rst req", 32'(imem_req), 32'h0);
        chk("rst valid", 32'(instr_valid), 32'h0);
        chk("rst fetch_error", 32'(fetch_error), 32'h0);

        @(negedge clock);
        reset_n = 1'b1;
        step();
        chk("first req", 32'(imem_req), 32'h1);
        chk("first addr", imem_addr, 32'h0);
        chk("first instr untouched", instr, 32'h0);

        // Table: ready held high, rdata garbled during execute
        exp_pc = 32'h0;
        for (int i = 0; i < 8; i++) begin
            imem_rdata = vecs[i].rdata;
            step();
            chk($sformatf("v%0d instr", i), instr, vecs[i].rdata);
            chk($sformatf("v%0d opcode", i), 32'(opcode), 32'(vecs[i].op));
            chk($sformatf("v%0d valid", i), 32'(instr_valid), 32'h1);
            chk($sformatf("v%0d req low", i), 32'(imem_req), 32'h0);
            imem_rdata = 32'hFFFF_FFFF;
            branch     = vecs[i].br;
            zero       = vecs[i].zr;
            jump       = vecs[i].jp;
            exec_done  = 1'b1;
            step();
            exec_done = 1'b0;
            branch    = 1'b0;
            zero      = 1'b0;
            jump      = 1'b0;
            exp_pc    = vecs[i].pc_after;
            chk($sformatf("v%0d pc", i), pc, exp_pc);
            chk($sformatf("v%0d addr", i), imem_addr, exp_pc);
            chk($sformatf("v%0d pc_plus4", i), pc_plus4, exp_pc + 32'd4);
            chk($sformatf("v%0d count", i), instr_count, 32'(i + 1));
            chk($sformatf("v%0d req", i), 32'(imem_req), 32'h1);
            if (i == 0) begin
                chk("wrap pc after commit", w_pc2, 32'h0);
            end
        end

        // Delayed ready, changing rdata, exec_done pulsed during fetch
        imem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            imem_rdata = 32'h1111_0000 + 32'(k);
            exec_done  = 1'b1;
            step();
            chk($sformatf("wait%0d req", k), 32'(imem_req), 32'h1);
            chk($sformatf("wait%0d addr", k), imem_addr, 32'h0040_0040);
            chk($sformatf("wait%0d valid", k), 32'(instr_valid), 32'h0);
        end
        exec_done = 1'b0;
        chk("wait count held", instr_count, 32'd8);
        chk("wait instr held", instr, 32'h2001_0005);
        imem_rdata = 32'h2002_0007;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'h3333_3333;
        chk("late instr", instr, 32'h2002_0007);
        chk("late opcode", 32'(opcode), 32'h08);
        chk("late valid", 32'(instr_valid), 32'h1);
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        chk("late pc", pc, 32'h0040_0044);
        chk("late count", instr_count, 32'd9);

        // Async reset in the middle of an execute cycle
        imem_rdata = 32'h8C01_0004;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("pre-reset valid", 32'(instr_valid), 32'h1);
        #3 reset_n = 1'b0;
        #1;
        chk("async pc", pc, 32'h0);
        chk("async count", instr_count, 32'h0);
        chk("async valid", 32'(instr_valid), 32'h0);
        chk("async req", 32'(imem_req), 32'h0);
        chk("async instr", instr, 32'h0);
        chk("async wrap pc", w_pc2, 32'hFFFF_FFFC);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        chk("post-reset req", 32'(imem_req), 32'h1);
        chk("post-reset addr", imem_addr, 32'h0);

`ifdef FETCH_TIMEOUT_EN
        // Ready on the 16th wait edge is accepted
        repeat (15) step();
        chk("to15 error", 32'(fetch_error), 32'h0);
        chk("to15 req", 32'(imem_req), 32'h1);
        imem_rdata = 32'hAC01_0008;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("to16 accepted valid", 32'(instr_valid), 32'h1);
        chk("to16 accepted instr", instr, 32'hAC01_0008);
        chk("to16 no error", 32'(fetch_error), 32'h0);
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        // Ready never comes: error after the 16th wait edge
        repeat (15) step();
        chk("tmo15 error", 32'(fetch_error), 32'h0);
        chk("tmo15 req", 32'(imem_req), 32'h1);
        step();
        chk("tmo16 error", 32'(fetch_error), 32'h1);
        chk("tmo16 req", 32'(imem_req), 32'h0);
        imem_ready = 1'b1;
        repeat (3) step();
        imem_ready = 1'b0;
        chk("tmo sticky error", 32'(fetch_error), 32'h1);
        chk("tmo req stays low", 32'(imem_req), 32'h0);
        chk("tmo valid low", 32'(instr_valid), 32'h0);
`else
        // Without the timeout, a long wait keeps requesting with no error
        repeat (20) step();
        chk("long wait req", 32'(imem_req), 32'h1);
        chk("long wait error", 32'(fetch_error), 32'h0);
        chk("long wait valid", 32'(instr_valid), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/busca_instrucao.md
Name: busca_instrucao

Overview:
- Instruction-fetch stage sitting directly upstream of the control unit.
- Holds the PC and fetches from a variable-latency instruction memory over a req/ready handshake.
- Presents the latched instruction and its opcode field [31:26] to the control unit.
- Commits the next PC (sequential, beq, or j) using the branch/jump/zero results returned from the datapath.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, maximum imem wait cycles; used only when FETCH_TIMEOUT_EN is defined.

Ports:
- clock  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equals pc.
- imem_ready  input  1  imem has valid data this cycle.
- imem_rdata  input  32  instruction word from imem.
- instr  output  32  latched instruction register.
- opcode  output  6  instr[31:26], drives control unit opcode.
- instr_valid  output  1  instr is stable and executing.
- pc  output  32  current PC.
- pc_plus4  output  32  pc + 4, combinational.
- branch  input  1  control-unit branch signal.
- zero  input  1  ALU zero flag.
- jump  input  1  control-unit jump signal.
- exec_done  input  1  datapath finished the current instruction; commit next PC.
- instr_count  output  32  number of committed instructions.
- fetch_error  output  1  sticky timeout flag; tied 0 without FETCH_TIMEOUT_EN.

Behaviour:
Reset (asynchronous, reset_n=0):
- pc=RESET_PC, instr=0, instr_count=0, fetch_error=0.
- State S_FETCH with imem_req forced 0 while reset_n=0; instr_valid=0.
- First request is issued in the first clock after reset_n rises.
- Reset mid-handshake abandons the fetch and discards any imem_ready/data in that cycle.

States:
- S_FETCH:
  - imem_req=1, instr_valid=0.
  - On clock edge with imem_ready=1: instr<=imem_rdata, go S_EXEC.
  - imem_ready may be high in the very first S_FETCH cycle, giving minimum fetch latency of 1 cycle.
  - exec_done is ignored in this state.
- S_EXEC:
  - imem_req=0, instr_valid=1; instr and opcode are held stable.
  - On clock edge with exec_done=1: pc<=next_pc, instr_count<=instr_count+1 (wraps 2^32-1 -> 0), go S_FETCH.
  - imem_ready is ignored in this state.
- S_ERROR (only with FETCH_TIMEOUT_EN):
  - imem_req=0, instr_valid=0.
  - Exit only via reset.

Next PC, evaluated only in the exec_done cycle (all arithmetic modulo 2^32):
- jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}. Jump has priority over branch when both are 1.
- else branch & zero: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
- else: pc_plus4.

Boundary and ordering rules:
- pc_plus4 = pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- branch, zero and jump are don't-care outside the exec_done cycle.
- imem_addr is stable for the entire request; imem_rdata is sampled only on the ready edge.
- One instruction in flight at a time; there is no overlap of fetch and execute.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - An 8-bit wait counter clears on entry to S_FETCH and increments each S_FETCH cycle with imem_ready=0.
  - If the counter reaches TIMEOUT_CYCLES with imem_ready still 0: fetch_error<=1 (sticky), go S_ERROR.
  - imem_ready=1 on the same edge the count reaches TIMEOUT_CYCLES is accepted normally; fetch succeeds, no error.
- Not defined:
  - No counter and no S_ERROR; the FSM waits indefinitely for imem_ready.
  - fetch_error is constant 0.

Test Plan:
- Reset release, imem_ready held 1, exec_done pulsed each S_EXEC: imem_addr sequence 0x0, 0x4, 0x8; instr_count=3 after third commit; opcode matches imem_rdata[31:26] (e.g. 0x8C010004 -> 6'b100011).
- pc=0x100, instr=0x1000_0003 (beq offset 3), branch=1, zero=1 at exec_done: next pc=0x110. Same instruction with zero=0: next pc=0x104.
- pc=0x0040_0000, instr=0x0810_0010, jump=1 and branch=1, zero=1 together: next pc=0x0040_0040 (jump wins).
- imem_ready delayed 5 cycles with imem_rdata changing in between: imem_req held 1, imem_addr stable; instr captures only the value present on the ready edge; exec_done pulsed during S_FETCH has no effect.
- Assert reset_n=0 asynchronously mid S_EXEC with pc=0x20, instr_count=7: pc=RESET_PC, instr_count=0, instr_valid=0 immediately, without waiting for a clock edge.
- With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16:
  - imem_ready never asserted: fetch_error=1 after 16 wait cycles; imem_req=0 thereafter and remains so until reset.
  - imem_ready asserted on the 16th wait edge: fetch succeeds, fetch_error stays 0.
